// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and default constants for the TMR fault manager slice.
package cv32e40p_tmr_pkg;

  typedef enum logic [1:0] {
    TMR_IDLE   = 2'd0,
    TMR_REQ    = 2'd1,
    TMR_SETTLE = 2'd2,
    TMR_ALARM  = 2'd3
  } tmr_fm_state_e;

  localparam int TMR_NUM_VOTERS    = 8;
  localparam int TMR_CNT_WIDTH     = 8;
  localparam int TMR_THRESHOLD     = 3;
  localparam int TMR_WINDOW        = 64;
  localparam int TMR_SETTLE_CYCLES = 4;
  localparam int TMR_MAX_RETRY     = 2;

endpackage

// File: rtl/cv32e40p_tmr_prio_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest 1 in vec, valid when any bit is set.
module cv32e40p_tmr_prio_enc
  import cv32e40p_tmr_pkg::*;
#(
  parameter int WIDTH = TMR_NUM_VOTERS,
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR voter fault collector: counts fault events, captures the first faulty voter, requests resyncs, raises a sticky alarm.
// Define CV32E40P_TMR_FAULT_LOG_EN to keep a sticky per-voter fault bitmap on fault_map_o.
module cv32e40p_tmr_fault_manager
  import cv32e40p_tmr_pkg::*;
#(
  parameter int NUM_VOTERS    = TMR_NUM_VOTERS,
  parameter int CNT_WIDTH     = TMR_CNT_WIDTH,
  parameter int THRESHOLD     = TMR_THRESHOLD,
  parameter int WINDOW        = TMR_WINDOW,
  parameter int SETTLE_CYCLES = TMR_SETTLE_CYCLES,
  parameter int MAX_RETRY     = TMR_MAX_RETRY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [NUM_VOTERS-1:0]         fault_vec_i,
  output logic                          resync_req_o,
  input  logic                          resync_ack_i,
  output logic [CNT_WIDTH-1:0]          fault_cnt_o,
  output logic                          first_valid_o,
  output logic [$clog2(NUM_VOTERS)-1:0] first_idx_o,
  output logic                          alarm_o,
  output logic [NUM_VOTERS-1:0]         fault_map_o,
  output tmr_fm_state_e                 fsm_state
);

  localparam int IW = $clog2(NUM_VOTERS);
  localparam int EW = $clog2(THRESHOLD + 1);
  localparam int TW = $clog2(WINDOW + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [EW-1:0]        THR         = EW'(THRESHOLD);
  localparam logic [TW-1:0]        WIN_LAST    = TW'(WINDOW - 1);
  localparam logic [RW-1:0]        RETRY_MAX   = RW'(MAX_RETRY);
  localparam logic [SW-1:0]        SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  tmr_fm_state_e   state;
  logic [EW-1:0]   ev_cnt, ev_base, ev_next;
  logic [TW-1:0]   timer, tm_base, timer_next;
  logic [TW-1:0]   quiet_cnt;
  logic [RW-1:0]   retry;
  logic [SW-1:0]   settle_cnt;
  logic [IW-1:0]   low_idx;
  logic            any_fault;
  logic            fault_event;
  logic            win_expire;

  cv32e40p_tmr_prio_enc #(.WIDTH(NUM_VOTERS)) u_prio_enc (
    .vec   (fault_vec_i),
    .idx   (low_idx),
    .valid (any_fault)
  );

  assign fault_event = enable_i && any_fault && (state != TMR_SETTLE);
  assign fsm_state   = state;

  // A window is open while ev_cnt is non-zero; an event on the expiry cycle opens the next one.
  always_comb begin
    win_expire = (ev_cnt != '0) && (timer == WIN_LAST);
    ev_base    = win_expire ? '0 : ev_cnt;
    tm_base    = win_expire ? '0 : timer;
    ev_next    = fault_event ? ev_base + 1'b1 : ev_base;
    timer_next = (ev_next != '0) ? tm_base + 1'b1 : '0;
  end

  // resync_req_o rises on entry to REQ and holds until a cycle with resync_ack_i=1;
  // clear_i may withdraw it without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= TMR_IDLE;
      resync_req_o  <= 1'b0;
      alarm_o       <= 1'b0;
      fault_cnt_o   <= '0;
      first_valid_o <= 1'b0;
      first_idx_o   <= '0;
      ev_cnt        <= '0;
      timer         <= '0;
      quiet_cnt     <= '0;
      retry         <= '0;
      settle_cnt    <= '0;
    end else if (clear_i) begin
      state         <= TMR_IDLE;
      resync_req_o  <= 1'b0;
      alarm_o       <= 1'b0;
      fault_cnt_o   <= '0;
      first_valid_o <= 1'b0;
      first_idx_o   <= '0;
      ev_cnt        <= '0;
      timer         <= '0;
      quiet_cnt     <= '0;
      retry         <= '0;
      settle_cnt    <= '0;
    end else begin
      if (fault_event && (fault_cnt_o != CNT_MAX)) fault_cnt_o <= fault_cnt_o + 1'b1;
      if (fault_event && !first_valid_o) begin
        first_valid_o <= 1'b1;
        first_idx_o   <= low_idx;
      end
      if (state != TMR_IDLE) quiet_cnt <= '0;

      case (state)
        TMR_IDLE: begin
          if (enable_i) begin
            ev_cnt <= ev_next;
            timer  <= timer_next;
            if (fault_event) begin
              quiet_cnt <= '0;
            end else if (quiet_cnt == WIN_LAST) begin
              quiet_cnt <= '0;
              retry     <= '0;
            end else begin
              quiet_cnt <= quiet_cnt + 1'b1;
            end
            if (fault_event && (ev_next == THR)) begin
              if (retry == RETRY_MAX) begin
                state   <= TMR_ALARM;
                alarm_o <= 1'b1;
              end else begin
                state        <= TMR_REQ;
                resync_req_o <= 1'b1;
                retry        <= retry + 1'b1;
              end
            end
          end
        end
        TMR_REQ: begin
          if (resync_ack_i) begin
            state        <= TMR_SETTLE;
            resync_req_o <= 1'b0;
            settle_cnt   <= SETTLE_LOAD;
          end
        end
        TMR_SETTLE: begin
          if (settle_cnt == '0) begin
            state  <= TMR_IDLE;
            ev_cnt <= '0;
            timer  <= '0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CV32E40P_TMR_FAULT_LOG_EN
  logic [NUM_VOTERS-1:0] map_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= '0;
    end else if (clear_i) begin
      map_q <= '0;
    end else if (fault_event) begin
      map_q <= map_q | fault_vec_i;
    end
  end

  assign fault_map_o = map_q;
`else
  assign fault_map_o = '0;
`endif

endmodule
